uart_csr_fifo: RTL

- Next-generation UART control/status register block: same local-bus slave interface, plus parametrised TX and RX data FIFOs, a programmable baud divisor, sticky overflow flags with write-1-to-clear, and a single level interrupt.
- Sits between the system local bus and the UART TX/RX shift engines.
- Replaces the single-byte TX_DATA/RX_DATA holding registers with FIFO push/pop semantics.

---
 rtl/uart_csr_pkg.sv | 40 ++++
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_csr_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_csr_pkg.sv
// Shared definitions for the UART CSR block: register offsets, CTRL/STAT
// bit positions and the divisor reset default.
package uart_csr_pkg;

  localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
  localparam logic [31:0] STAT_OFF   = 32'h0000_0004;
  localparam logic [31:0] DATA_OFF   = 32'h0000_0008;
  localparam logic [31:0] DIV_OFF    = 32'h0000_000C;
  localparam logic [31:0] THRESH_OFF = 32'h0000_0010;

  localparam int CTRL_UART_EN   = 0;
  localparam int CTRL_TX_EN     = 1;
  localparam int CTRL_RX_EN     = 2;
  localparam int CTRL_TX_IRQ_EN = 3;
  localparam int CTRL_RX_IRQ_EN = 4;
  localparam int CTRL_TX_FLUSH  = 5;
  localparam int CTRL_RX_FLUSH  = 6;

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_TX_EMPTY   = 1;
  localparam int STAT_RX_FULL    = 2;
  localparam int STAT_RX_EMPTY   = 3;
  localparam int STAT_RX_OVF     = 4;
  localparam int STAT_TX_OVF     = 5;
  localparam int STAT_TX_LVL_LSB = 8;
  localparam int STAT_RX_LVL_LSB = 16;

  // 115200 baud from a 100 MHz clock
  localparam int DIV_RST_DEFAULT = 868;

  // Stored CTRL bits; the flush bits are pulses and are never stored.
  typedef struct packed {
    logic rx_irq_en;
    logic tx_irq_en;
    logic rx_en;
    logic tx_en;
    logic uart_en;
  } ctrl_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with push/pop/flush. Pop on empty is ignored; push on full
// is accepted only when a pop happens in the same cycle. Flush beats both.
// The head reads as zero while the FIFO is empty.
module uart_sync_fifo
  import uart_csr_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_csr_fifo.sv
// UART control/status register block with TX/RX FIFOs, baud divisor, sticky
// overflow flags (write-1-to-clear) and a registered level interrupt.
// Optional macro UART_CSR_RX_THRESH_EN adds the RX threshold register at 0x10;
// without it the RX interrupt threshold is fixed at 1.
// Bus handshake: writes always accepted (wready=1) on the cycle wen is high;
// reads are combinational from raddr and rvalid mirrors ren; an RX pop fires
// only on the first cycle of a DATA read.
module uart_csr_fifo
  import uart_csr_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              TX_DEPTH = 8,
  parameter int              RX_DEPTH = 8,
  parameter int              DIV_W    = 16,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       waddr,
  input  logic [31:0]       wdata,
  input  logic              wen,
  input  logic [3:0]        wstrb,
  output logic              wready,
  input  logic [31:0]       raddr,
  input  logic              ren,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              uart_en_o,
  output logic              tx_en_o,
  output logic              rx_en_o,
  output logic [DIV_W-1:0]  baud_div_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              irq_o
);

  localparam int TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int RX_LW = $clog2(RX_DEPTH) + 1;

  ctrl_t             ctrl_q;
  logic              tx_ovf_q;
  logic              rx_ovf_q;
  logic [DIV_W-1:0]  div_q;
  logic              ren_ff_data;
  logic              irq_q;
  logic [RX_LW-1:0]  thresh;

  logic              wr_ctrl, wr_stat, wr_div;
  logic              tx_push, tx_pop, tx_flush;
  logic              rx_rd, rx_push, rx_pop, rx_flush;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_LW-1:0]  tx_level;
  logic [RX_LW-1:0]  rx_level;
  logic [DATA_W-1:0] rx_head;
  logic [31:0]       wmask;
  logic [31:0]       div_wr_val;
  logic              irq_next;
  logic [31:0]       stat_word;

  // Bus decode
  assign wr_ctrl  = wen && (waddr == CTRL_OFF) && wstrb[0];
  assign wr_stat  = wen && (waddr == STAT_OFF) && wstrb[0];
  assign wr_div   = wen && (waddr == DIV_OFF);
  assign tx_push  = wen && (waddr == DATA_OFF) && wstrb[0];
  assign tx_flush = wr_ctrl && wdata[CTRL_TX_FLUSH];
  assign rx_flush = wr_ctrl && wdata[CTRL_RX_FLUSH];
  assign rx_rd    = ren && (raddr == DATA_OFF);
  assign rx_pop   = rx_rd && !ren_ff_data;
  assign rx_push  = rx_valid_i && ctrl_q.uart_en && ctrl_q.rx_en;
  assign tx_pop   = tx_valid_o && tx_ready_i;

  assign wready     = 1'b1;
  assign rvalid     = ren;
  assign uart_en_o  = ctrl_q.uart_en;
  assign tx_en_o    = ctrl_q.tx_en;
  assign rx_en_o    = ctrl_q.rx_en;
  assign baud_div_o = div_q;
  assign tx_valid_o = !tx_empty && ctrl_q.uart_en && ctrl_q.tx_en;
  assign irq_o      = irq_q;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tx_flush),
    .push  (tx_push),
    .wdata (wdata[DATA_W-1:0]),
    .pop   (tx_pop),
    .rdata (tx_data_o),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  uart_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rx_flush),
    .push  (rx_push),
    .wdata (rx_data_i),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // Byte-lane merge for the divisor register
  assign wmask      = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign div_wr_val = (32'(div_q) & ~wmask) | (wdata & wmask);

  // CTRL, divisor and read-edge tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      div_q       <= DIV_RST;
      ren_ff_data <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= ctrl_t'(wdata[4:0]);
      if (wr_div)  div_q  <= div_wr_val[DIV_W-1:0];
      ren_ff_data <= rx_rd;
    end
  end

  // Sticky overflow flags: a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_ovf_q <= (tx_ovf_q && !(wr_stat && wdata[STAT_TX_OVF]))
                  || (tx_push && tx_full && !tx_pop && !tx_flush);
      rx_ovf_q <= (rx_ovf_q && !(wr_stat && wdata[STAT_RX_OVF]))
                  || (rx_push && rx_full && !rx_pop && !rx_flush);
    end
  end

`ifdef UART_CSR_RX_THRESH_EN
  logic             wr_thresh;
  logic [RX_LW-1:0] thresh_q;

  assign wr_thresh = wen && (waddr == THRESH_OFF) && wstrb[0];
  assign thresh    = thresh_q;

  // Programmable RX threshold: zero is stored as 1, large values saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_q <= RX_LW'(1);
    end else if (wr_thresh) begin
      if (wdata == 32'd0)
        thresh_q <= RX_LW'(1);
      else if (wdata > 32'(RX_DEPTH))
        thresh_q <= RX_LW'(RX_DEPTH);
      else
        thresh_q <= RX_LW'(wdata);
    end
  end
`else
  assign thresh = RX_LW'(1);
`endif

  // Interrupt cause, registered below for a one-cycle latency.
  always_comb begin
    irq_next = (ctrl_q.tx_irq_en && tx_empty)
            || (ctrl_q.rx_irq_en && (rx_level >= thresh))
            || rx_ovf_q || tx_ovf_q;
  end

  // Registered level interrupt.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_next;
  end

  // STAT word assembly.
  always_comb begin
    stat_word                                   = '0;
    stat_word[STAT_TX_FULL]                     = tx_full;
    stat_word[STAT_TX_EMPTY]                    = tx_empty;
    stat_word[STAT_RX_FULL]                     = rx_full;
    stat_word[STAT_RX_EMPTY]                    = rx_empty;
    stat_word[STAT_RX_OVF]                      = rx_ovf_q;
    stat_word[STAT_TX_OVF]                      = tx_ovf_q;
    stat_word[STAT_TX_LVL_LSB+7:STAT_TX_LVL_LSB] = 8'(tx_level);
    stat_word[STAT_RX_LVL_LSB+7:STAT_RX_LVL_LSB] = 8'(rx_level);
  end

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    rdata = '0;
    case (raddr)
      CTRL_OFF:   rdata = 32'(ctrl_q);
      STAT_OFF:   rdata = stat_word;
      DATA_OFF:   rdata = {!rx_empty, 23'b0, 8'(rx_head)};
      DIV_OFF:    rdata = 32'(div_q);
`ifdef UART_CSR_RX_THRESH_EN
      THRESH_OFF: rdata = 32'(thresh_q);
`endif
      default:    rdata = '0;
    endcase
  end

  // Bits of the merged divisor word beyond DIV_W are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{div_wr_val, wdata};

endmodule
